// File: rtl/aer_spike_rx_pkg.sv
// rtl/aer_spike_rx_pkg.sv - shared AER packet format and drain-state constants
// Purpose: packet field offsets and widths shared with the transmit side,
//          drain FSM state encoding, and a packet builder helper.
package aer_spike_rx_pkg;

    // Packet format shared by the transmit and receive paths
    localparam int AER_PKT_WIDTH   = 32;
    localparam int AER_COORD_WIDTH = 8;
    localparam int AER_AXON_WIDTH  = 16;

    // Field offsets: [31:24] dest X, [23:16] dest Y, [15:0] axon index
    localparam int AER_X_MSB    = 31;
    localparam int AER_X_LSB    = 24;
    localparam int AER_Y_MSB    = 23;
    localparam int AER_Y_LSB    = 16;
    localparam int AER_AXON_MSB = 15;
    localparam int AER_AXON_LSB = 0;

    // Drain control states
    localparam logic [0:0] DRAIN_IDLE   = 1'b0;
    localparam logic [0:0] DRAIN_ACTIVE = 1'b1;

    function automatic logic [AER_PKT_WIDTH-1:0] aer_pack(
        input logic [AER_COORD_WIDTH-1:0] x,
        input logic [AER_COORD_WIDTH-1:0] y,
        input logic [AER_AXON_WIDTH-1:0]  axon
    );
        return {x, y, axon};
    endfunction

endpackage

// File: rtl/aer_spike_rx_if.sv
// rtl/aer_spike_rx_if.sv - AER packet valid/ready link between router and core
// Purpose: carries one packet per accepted handshake.
// Signals: pkt_i (packet), pkt_valid_i (packet valid), pkt_ready_o (receiver can accept).
// Modports: master = router side, slave = receiver side.
interface aer_spike_rx_if
    import aer_spike_rx_pkg::*;
#(
    parameter int AER_BIT_WIDTH = AER_PKT_WIDTH
) ();

    logic [AER_BIT_WIDTH-1:0] pkt_i;
    logic                     pkt_valid_i;
    logic                     pkt_ready_o;

    modport master (
        output pkt_i,
        output pkt_valid_i,
        input  pkt_ready_o
    );

    modport slave (
        input  pkt_i,
        input  pkt_valid_i,
        output pkt_ready_o
    );

endinterface

// File: rtl/aer_sync_fifo.sv
// rtl/aer_sync_fifo.sv - parameterised synchronous FIFO
// Purpose: single-clock FIFO with show-ahead read data.
// Ports: clk_i, rst_n_i (sync, active-low), i_push/i_data (write side),
//        i_pop/o_data (read side, o_data valid while !o_empty),
//        o_full, o_empty, o_count (current occupancy).
module aer_sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_pop,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [PTR_WIDTH:0]   o_count
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    // Extra MSB separates full (MSBs differ) from empty (pointers equal)
    logic [PTR_WIDTH:0] r_wr_ptr;
    logic [PTR_WIDTH:0] r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]) &&
                       (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_mem[r_rd_ptr[PTR_WIDTH-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= i_data;
    end

endmodule

// File: rtl/aer_spike_rx.sv
// rtl/aer_spike_rx.sv - AER spike receiver: ingress FIFO, decode, per-timestep accumulate
// Purpose: buffers incoming AER packets, sets one accumulator bit per valid
//          packet, and transfers the accumulator to inSpike_o on each start_i.
// Ports: clk_i, rst_n_i (sync, active-low), pkt_if (slave: pkt_i, pkt_valid_i, pkt_ready_o),
//        start_i (timestep pulse), inSpike_o (spike vector), fifo_empty_o,
//        drop_cnt_o (saturating count of rejected packets).
module aer_spike_rx
    import aer_spike_rx_pkg::*;
#(
    parameter int         NUM_AXONS          = 2,
    parameter int         AXON_CNT_BIT_WIDTH = 1,
    parameter int         AER_BIT_WIDTH      = 32,
    parameter logic [7:0] X_ID               = 8'd1,
    parameter logic [7:0] Y_ID               = 8'd1,
    parameter int         FIFO_DEPTH         = 4,
    parameter int         FIFO_PTR_WIDTH     = 2,
    parameter int         DROP_CNT_WIDTH     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    aer_spike_rx_if.slave             pkt_if,
    input  logic                      start_i,
    output logic [NUM_AXONS-1:0]      inSpike_o,
    output logic                      fifo_empty_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    logic [AER_BIT_WIDTH-1:0]      w_head;
    logic                          w_full;
    logic                          w_empty;
    logic [FIFO_PTR_WIDTH:0]       w_count;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_hit;
    logic [AER_AXON_WIDTH-1:0]     w_axon;
    logic [AXON_CNT_BIT_WIDTH-1:0] w_axon_idx;
    logic [NUM_AXONS-1:0]          w_acc_next;
    logic [0:0]                    w_state_next;

    logic [0:0]                    r_state;
    logic [NUM_AXONS-1:0]          r_acc;
    logic [NUM_AXONS-1:0]          r_in_spike;
    logic [DROP_CNT_WIDTH-1:0]     r_drop_cnt;

    assign pkt_if.pkt_ready_o = !w_full;
    assign w_push             = pkt_if.pkt_valid_i && !w_full;
    // DRAIN implies non-empty; the empty term only guards the invariant
    assign w_pop              = (r_state == DRAIN_ACTIVE) && !w_empty;

    aer_sync_fifo #(
        .WIDTH     (AER_BIT_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .PTR_WIDTH (FIFO_PTR_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_push  (w_push),
        .i_data  (pkt_if.pkt_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_axon     = w_head[AER_AXON_MSB:AER_AXON_LSB];
    assign w_axon_idx = w_axon[AXON_CNT_BIT_WIDTH-1:0];
    assign w_hit      = (w_head[AER_X_MSB:AER_X_LSB] == X_ID) &&
                        (w_head[AER_Y_MSB:AER_Y_LSB] == Y_ID) &&
                        (int'(w_axon) < NUM_AXONS);

    // A pop coinciding with start_i lands in the freshly cleared accumulator,
    // so that spike belongs to the next timestep.
    always_comb begin
        w_acc_next = start_i ? '0 : r_acc;
        if (w_pop && w_hit) w_acc_next[w_axon_idx] = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DRAIN_IDLE:   if (w_push) w_state_next = DRAIN_ACTIVE;
            DRAIN_ACTIVE: if (w_pop && !w_push &&
                              (w_count == {{FIFO_PTR_WIDTH{1'b0}}, 1'b1}))
                              w_state_next = DRAIN_IDLE;
            default:      w_state_next = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= DRAIN_IDLE;
            r_acc      <= '0;
            r_in_spike <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            if (start_i) r_in_spike <= r_acc;
            if (w_pop && !w_hit && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
        end
    end

    assign inSpike_o    = r_in_spike;
    assign fifo_empty_o = w_empty;
    assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: tb/tb_aer_spike_rx.sv
// tb/tb_aer_spike_rx.sv - self-checking bench for aer_spike_rx
module tb_aer_spike_rx;
    import aer_spike_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] in_spike;
    logic       fifo_empty;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    aer_spike_rx_if #(.AER_BIT_WIDTH(32)) pkt_if ();

    aer_spike_rx dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .pkt_if       (pkt_if),
        .start_i      (start),
        .inSpike_o    (in_spike),
        .fifo_empty_o (fifo_empty),
        .drop_cnt_o   (drop_cnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a packet queue, accumulator, output vector, drop count
    logic [31:0] m_q[$];
    logic [1:0]  m_acc;
    logic [1:0]  m_in;
    int          m_drop;
    logic        last_rdy;

    typedef struct {
        logic [31:0] pkt;
        logic        vld;
        logic        st;
        logic [1:0]  exp_in;
        logic [7:0]  exp_drop;
    } vec_t;
    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_hit(input logic [31:0] p);
        return (p[31:24] == 8'd1) && (p[23:16] == 8'd1) && (p[15:0] < 16'd2);
    endfunction

    // One clock cycle: drive, check ready, advance the model across the edge, check outputs
    task automatic step(input logic [31:0] pkt, input logic vld, input logic st);
        logic        pop;
        logic        push;
        logic [31:0] head;
        logic [1:0]  nacc;
        pkt_if.pkt_i       = pkt;
        pkt_if.pkt_valid_i = vld;
        start              = st;
        #1;
        last_rdy = pkt_if.pkt_ready_o;
        chk("ready", {31'd0, pkt_if.pkt_ready_o}, {31'd0, m_q.size() < 4});
        pop  = m_q.size() > 0;
        push = vld && (m_q.size() < 4);
        head = pop ? m_q[0] : 32'd0;
        if (st) m_in = m_acc;
        nacc = st ? 2'b00 : m_acc;
        if (pop) begin
            void'(m_q.pop_front());
            if (is_hit(head)) nacc[head[0]] = 1'b1;
            else if (m_drop < 255) m_drop++;
        end
        if (push) m_q.push_back(pkt);
        m_acc = nacc;
        @(posedge clk);
        #1;
        chk("inSpike", {30'd0, in_spike}, {30'd0, m_in});
        chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
        chk("fifo_empty", {31'd0, fifo_empty}, {31'd0, m_q.size() == 0});
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        pkt_if.pkt_valid_i = 1'b0;
        pkt_if.pkt_i       = 32'd0;
        start              = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_q.delete();
        m_acc  = 2'b00;
        m_in   = 2'b00;
        m_drop = 0;
        chk("rst_inSpike", {30'd0, in_spike}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
        chk("rst_ready", {31'd0, pkt_if.pkt_ready_o}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{32'h0101_0001, 1'b1, 1'b0, 2'b00, 8'd0};
        vecs[1]  = '{32'h0,         1'b0, 1'b0, 2'b00, 8'd0};
        vecs[2]  = '{32'h0,         1'b0, 1'b0, 2'b00, 8'd0};
        vecs[3]  = '{32'h0,         1'b0, 1'b0, 2'b00, 8'd0};
        vecs[4]  = '{32'h0,         1'b0, 1'b0, 2'b00, 8'd0};
        vecs[5]  = '{32'h0,         1'b0, 1'b1, 2'b10, 8'd0};
        vecs[6]  = '{32'h0,         1'b0, 1'b0, 2'b10, 8'd0};
        vecs[7]  = '{32'h0101_0000, 1'b1, 1'b0, 2'b10, 8'd0};
        vecs[8]  = '{32'h0101_0001, 1'b1, 1'b0, 2'b10, 8'd0};
        vecs[9]  = '{32'h0101_0001, 1'b1, 1'b0, 2'b10, 8'd0};
        vecs[10] = '{32'h0,         1'b0, 1'b0, 2'b10, 8'd0};
        vecs[11] = '{32'h0,         1'b0, 1'b0, 2'b10, 8'd0};
        vecs[12] = '{32'h0,         1'b0, 1'b1, 2'b11, 8'd0};
        vecs[13] = '{32'h0,         1'b0, 1'b1, 2'b00, 8'd0};
        vecs[14] = '{32'h0201_0000, 1'b1, 1'b0, 2'b00, 8'd0};
        vecs[15] = '{32'h0101_0005, 1'b1, 1'b0, 2'b00, 8'd1};
        vecs[16] = '{32'h0,         1'b0, 1'b0, 2'b00, 8'd2};
        vecs[17] = '{32'h0,         1'b0, 1'b1, 2'b00, 8'd2};

        do_reset();

        // Directed table: single spike, duplicates, empty timestep, bad packets
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].pkt, vecs[i].vld, vecs[i].st);
            chk($sformatf("vec%0d_inSpike", i), {30'd0, in_spike}, {30'd0, vecs[i].exp_in});
            chk($sformatf("vec%0d_drop", i), {24'd0, drop_cnt}, {24'd0, vecs[i].exp_drop});
        end

        // Drop counter saturation
        for (int i = 0; i < 300; i++) step(32'h0201_0000, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        chk("drop_saturate", {24'd0, drop_cnt}, 32'd255);

        // Back-to-back packets at full rate
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(aer_pack(8'd1, 8'd1, 16'(i % 2)), 1'b1, 1'b0);
            chk("tput_ready", {31'd0, last_rdy}, 32'd1);
        end
        step(32'h0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b1);
        chk("tput_inSpike", {30'd0, in_spike}, 32'd3);
        chk("tput_empty", {31'd0, fifo_empty}, 32'd1);

        // Pop coinciding with start goes to the next timestep
        step(32'h0, 1'b0, 1'b1);
        step(32'h0101_0000, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b1);
        chk("samecyc_now", {30'd0, in_spike}, 32'd0);
        step(32'h0, 1'b0, 1'b1);
        chk("samecyc_next", {30'd0, in_spike}, 32'd1);

        // Reset mid-operation with a pending spike and a queued packet
        step(32'h0101_0000, 1'b1, 1'b0);
        step(32'h0101_0001, 1'b1, 1'b0);
        step(32'h0101_0001, 1'b1, 1'b0);
        do_reset();
        step(32'h0, 1'b0, 1'b1);
        chk("post_rst_start", {30'd0, in_spike}, 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 500; i++) begin
            logic [7:0]  x;
            logic [7:0]  y;
            logic [15:0] ax;
            x  = ($urandom_range(0, 5) == 0) ? 8'd2 : 8'd1;
            y  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'd1;
            ax = 16'($urandom_range(0, 2));
            step(aer_pack(x, y, ax), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
